// File: rtl/hs_arith_frame_accum.sv
// Frame accumulator: sums a programmable number of adder beats per frame behind valid/ready.
// Optional macro HS_ARITH_FRAME_ACCUM_OVERLAP_EN lets the next frame accumulate while a result is held.
module hs_arith_frame_accum #(
  parameter int IN_WIDTH  = 5,
  parameter int FRAME_MAX = 16,
  localparam int CNT_WIDTH = $clog2(FRAME_MAX + 1),
  localparam int ACC_WIDTH = $clog2(FRAME_MAX * (2**IN_WIDTH - 1) + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_WIDTH-1:0] frame_len,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [CNT_WIDTH-1:0] out_count
);

  typedef enum logic {ACC, HOLD} state_t;

  localparam logic [CNT_WIDTH-1:0] FMAX = CNT_WIDTH'(FRAME_MAX);

  state_t                 state, state_nxt;
  logic [CNT_WIDTH-1:0]   cnt, len_q, len_clamp, len_eff, cnt_inc;
  logic [ACC_WIDTH-1:0]   acc, beat;
  logic                   accept, beat_close, flush_close, close, can_load;

  always_comb begin
    if (frame_len == '0)
      len_clamp = CNT_WIDTH'(1);
    else if (frame_len > FMAX)
      len_clamp = FMAX;
    else
      len_clamp = frame_len;
  end

  // The first beat of a frame uses the live clamped length; later beats use the stored one.
  assign len_eff     = (cnt == '0) ? len_clamp : len_q;
  assign cnt_inc     = cnt + 1'b1;
  assign accept      = in_valid && in_ready;
  assign beat        = accept ? ACC_WIDTH'(in_data) : '0;
  assign can_load    = !out_valid || out_ready;
  assign beat_close  = accept && (cnt_inc == len_eff);
  assign flush_close = flush && ((cnt != '0) || accept) && can_load;
  assign close       = beat_close || flush_close;

`ifdef HS_ARITH_FRAME_ACCUM_OVERLAP_EN
  logic closes_next;
  assign closes_next = flush || (cnt_inc == len_eff);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ACC;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (close) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = close ? HOLD : ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_comb begin
    out_valid = (state == HOLD);
`ifdef HS_ARITH_FRAME_ACCUM_OVERLAP_EN
    in_ready  = !(out_valid && !out_ready && closes_next);
`else
    in_ready  = (state == ACC);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      len_q     <= '0;
      out_sum   <= '0;
      out_count <= '0;
    end else begin
      if (accept && (cnt == '0))
        len_q <= len_clamp;
      if (close) begin
        out_sum   <= acc + beat;
        out_count <= cnt + CNT_WIDTH'(accept);
        acc       <= '0;
        cnt       <= '0;
      end else if (accept) begin
        acc <= acc + beat;
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_hs_arith_frame_accum.sv
// Randomised and directed bench for hs_arith_frame_accum against a frame-level reference model.
// Honours HS_ARITH_FRAME_ACCUM_OVERLAP_EN for the in_ready policy.
module tb_hs_arith_frame_accum;

  localparam int IN_WIDTH  = 5;
  localparam int FRAME_MAX = 16;
  localparam int CNT_WIDTH = 5;
  localparam int ACC_WIDTH = 9;

  logic                 clk, rst;
  logic [CNT_WIDTH-1:0] frame_len;
  logic                 flush, in_valid, in_ready, out_valid, out_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic [ACC_WIDTH-1:0] out_sum;
  logic [CNT_WIDTH-1:0] out_count;

  int checks = 0;
  int errors = 0;

  hs_arith_frame_accum #(.IN_WIDTH(IN_WIDTH), .FRAME_MAX(FRAME_MAX)) dut (
    .clk(clk), .rst(rst), .frame_len(frame_len), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampf(input int fl);
    if (fl == 0) return 1;
    if (fl > FRAME_MAX) return FRAME_MAX;
    return fl;
  endfunction

  // Reference model: open frame kept as a list of beats, held result as plain ints.
  bit m_held;
  int m_sum, m_cnt, m_len;
  int q[$];

  always @(negedge clk) begin
    int sz, eff, s;
    bit exp_ready, acc_b, bclose, fclose;
    if (rst) begin
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_in_ready", int'(in_ready), 1);
      chk("reset_out_sum", int'(out_sum), 0);
      chk("reset_out_count", int'(out_count), 0);
      m_held = 1'b0;
      m_len  = 0;
      q.delete();
    end else begin
      sz  = q.size();
      eff = (sz == 0) ? clampf(int'(frame_len)) : m_len;
`ifdef HS_ARITH_FRAME_ACCUM_OVERLAP_EN
      exp_ready = !(m_held && !out_ready && (flush || (sz + 1 == eff)));
`else
      exp_ready = !m_held;
`endif
      chk("in_ready", int'(in_ready), int'(exp_ready));
      chk("out_valid", int'(out_valid), int'(m_held));
      if (m_held) begin
        chk("out_sum", int'(out_sum), m_sum);
        chk("out_count", int'(out_count), m_cnt);
      end
      acc_b  = in_valid && exp_ready;
      bclose = acc_b && (sz + 1 == eff);
      fclose = flush && (sz > 0 || acc_b) && (!m_held || out_ready);
      if (acc_b) begin
        if (sz == 0) m_len = eff;
        q.push_back(int'(in_data));
      end
      if (bclose || fclose) begin
        s = 0;
        foreach (q[i]) s += q[i];
        m_sum  = s;
        m_cnt  = q.size();
        m_held = 1'b1;
        q.delete();
      end else if (m_held && out_ready) begin
        m_held = 1'b0;
      end
    end
  end

  // Drive one beat and wait until it is accepted; returns at posedge+1.
  task automatic beat(input int d, input bit f);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_data  = IN_WIDTH'(d);
    flush    = f;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("beat_accepted", int'(got), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic wait_out(input string name, input int es, input int ec);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_valid"}, int'(seen), 1);
    chk({name, "_sum"}, int'(out_sum), es);
    chk({name, "_count"}, int'(out_count), ec);
    @(posedge clk); #1;
  endtask

  initial begin
    int n, exp_n;
    rst = 1'b1; frame_len = '0; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("lit_reset_in_ready", int'(in_ready), 1);
    rst = 1'b0;

    // Basic frame: 1+2+3+4
    frame_len = 5'd4;
    for (int i = 1; i <= 4; i++) beat(i, 1'b0);
    @(negedge clk);
    chk("basic_latency_valid", int'(out_valid), 1);
    chk("basic_sum", int'(out_sum), 10);
    chk("basic_count", int'(out_count), 4);
    n = in_ready ? 0 : 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (!in_ready) n++;
    end
`ifdef HS_ARITH_FRAME_ACCUM_OVERLAP_EN
    exp_n = 0;
`else
    exp_n = 1;
`endif
    chk("basic_bubble_cycles", n, exp_n);
    @(posedge clk); #1;

    frame_len = 5'd16;
    for (int i = 0; i < 16; i++) beat(31, 1'b0);
    wait_out("max_frame", 496, 16);

    frame_len = 5'd0;
    beat(7, 1'b0);
    wait_out("clamp_zero", 7, 1);

    frame_len = 5'd20;
    for (int i = 0; i < 16; i++) beat(1, 1'b0);
    wait_out("clamp_high", 16, 16);

    frame_len = 5'd8;
    beat(5, 1'b0); beat(5, 1'b0); beat(5, 1'b1);
    wait_out("flush", 15, 3);
    flush = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) n++;
      if (i == 2) begin
        @(posedge clk); #1;
        flush = 1'b0;
      end
    end
    chk("idle_flush_no_output", n, 0);
    @(posedge clk); #1;

    // Backpressure with a result held for 5 cycles
    out_ready = 1'b0;
    frame_len = 5'd2;
    beat(1, 1'b0); beat(2, 1'b0);
    in_valid = 1'b1; in_data = 5'd1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_sum", int'(out_sum), 3);
      chk("bp_count", int'(out_count), 2);
      if (in_ready) n++;
      if (i < 4) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
`ifdef HS_ARITH_FRAME_ACCUM_OVERLAP_EN
    exp_n = 1;
`else
    exp_n = 0;
`endif
    chk("bp_accepted_beats", n, exp_n);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
`ifndef HS_ARITH_FRAME_ACCUM_OVERLAP_EN
    beat(1, 1'b0);
`endif
    beat(9, 1'b0);
    wait_out("bp_next_frame", 10, 2);

    // Reset while a result is held, then reset mid-frame
    out_ready = 1'b0;
    frame_len = 5'd1;
    beat(6, 1'b0);
    @(negedge clk);
    chk("held_before_reset", int'(out_valid), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("reset_drops_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    frame_len = 5'd4;
    beat(1, 1'b0); beat(1, 1'b0);
    rst = 1'b1;
    #1;
    chk("reset_midframe_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    frame_len = 5'd2;
    beat(3, 1'b0); beat(4, 1'b0);
    wait_out("after_reset", 7, 2);

    // Random traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = IN_WIDTH'($urandom_range(0, 31));
      flush     = ($urandom_range(0, 15) == 0);
      frame_len = ($urandom_range(0, 7) == 0) ? CNT_WIDTH'($urandom_range(16, 31))
                                              : CNT_WIDTH'($urandom_range(0, 5));
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 499) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
